// File: rtl/sipo_rx.sv
// LSB-first serial-to-parallel receiver with a one-word valid/ready holding register and sticky overrun.
// Optional even-parity bit after the MSB when SIPO_PARITY_EN is defined; otherwise parity_err is tied low.
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err,
  output logic             busy
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = (FRAME > 2) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  // State is carried by the bit counter; this enum only names it.
  typedef enum logic {
    COLLECT = 1'b0,
    LAST    = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_overrun;

  state_t           w_state;
  logic [CW-1:0]    w_eff_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_done;
  logic             w_slot_free;
  logic             w_load;
  logic             w_drop;
  logic             w_vld_nxt;
  logic             w_ovr_nxt;

  always_comb begin
    w_eff_cnt   = sync ? '0 : r_cnt;
    w_state     = (w_eff_cnt == LAST_CNT) ? LAST : COLLECT;
    w_sr_nxt    = sync ? '0 : r_sr;
    w_cnt_nxt   = w_eff_cnt;
    w_done      = 1'b0;

    for (int k = 0; k < WIDTH; k++) begin
      if (sin_valid && (w_eff_cnt == CW'(k))) begin
        w_sr_nxt[k] = sin;
      end
    end

    if (sin_valid) begin
      if (w_state == LAST) begin
        w_cnt_nxt = '0;
        w_done    = 1'b1;
      end else begin
        w_cnt_nxt = w_eff_cnt + CW'(1);
      end
    end

    // A word completing on the same edge the consumer accepts reuses the slot.
    w_slot_free = !r_out_valid || out_ready;
    w_load      = w_done && w_slot_free;
    w_drop      = w_done && !w_slot_free;

    w_out_nxt   = w_load ? w_sr_nxt : r_out;

    if (w_load) begin
      w_vld_nxt = 1'b1;
    end else if (r_out_valid && out_ready) begin
      w_vld_nxt = 1'b0;
    end else begin
      w_vld_nxt = r_out_valid;
    end

    if (w_drop) begin
      w_ovr_nxt = 1'b1;
    end else if (ovr_clr) begin
      w_ovr_nxt = 1'b0;
    end else begin
      w_ovr_nxt = r_overrun;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr        <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sr        <= w_sr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_vld_nxt;
      r_overrun   <= w_ovr_nxt;
    end
  end

`ifdef SIPO_PARITY_EN
  logic r_parity_err;
  logic w_par_nxt;

  // At completion all data bits already sit in r_sr and sin is the parity bit.
  always_comb begin
    w_par_nxt = w_load ? ((^r_sr) ^ sin) : r_parity_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_par_nxt;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_cnt != '0);

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH=4); parity steps are included when SIPO_PARITY_EN is defined.
module tb_sipo_rx;
  logic       clk;
  logic       reset;
  logic       sin;
  logic       sin_valid;
  logic       sync;
  logic       out_ready;
  logic       ovr_clr;
  logic [3:0] out;
  logic       out_valid;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  sipo_rx #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sync       (sync),
    .out_ready  (out_ready),
    .ovr_clr    (ovr_clr),
    .out        (out),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
    sin       = 1'b0;
  endtask

  // Sends 4 data bits LSB first, then (parity build) the even-parity bit, optionally inverted.
  task automatic send_frame(input logic [3:0] d, input logic bad_par);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
`ifdef SIPO_PARITY_EN
    send_bit((^d) ^ bad_par);
`else
    if (bad_par) send_bit(1'b0);
`endif
  endtask

  initial begin
    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0;
    out_ready = 1'b0; ovr_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_out",   out,        4'h0);
    chk("rst_vld",   out_valid,  1'b0);
    chk("rst_ovr",   overrun,    1'b0);
    chk("rst_par",   parity_err, 1'b0);
    chk("rst_busy",  busy,       1'b0);

    // Reset mid-frame takes effect without a clock edge.
    send_bit(1'b1); send_bit(1'b1);
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", busy,      1'b0);
    chk("async_rst_vld",  out_valid, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    send_frame(4'hB, 1'b0);
    chk("post_rst_out", out,       4'hB);
    chk("post_rst_vld", out_valid, 1'b1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("post_rst_acc", out_valid, 1'b0);

    // Basic word with latency check.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("basic_pre_vld",  out_valid, 1'b0);
    chk("basic_pre_busy", busy,      1'b1);
    send_bit(1'b1);
`ifdef SIPO_PARITY_EN
    chk("basic_par_vld", out_valid, 1'b0);
    send_bit(1'b1);
`endif
    chk("basic_out",  out,        4'hB);
    chk("basic_vld",  out_valid,  1'b1);
    chk("basic_busy", busy,       1'b0);
    chk("basic_par",  parity_err, 1'b0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("basic_acc_vld", out_valid, 1'b0);
    chk("basic_acc_out", out,       4'hB);

    // Gapped word 6: bits 0,1, gap, 1,0.
    send_bit(1'b0); send_bit(1'b1);
    tick(); tick(); tick();
    chk("gap_busy", busy,      1'b1);
    chk("gap_vld",  out_valid, 1'b0);
    send_bit(1'b1); send_bit(1'b0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0);
`endif
    chk("gap_out", out,       4'h6);
    chk("gap_vld2", out_valid, 1'b1);

    // Stream F; accept the held 6 on the completion edge so valid never drops.
    send_bit(1'b1);
    chk("b2b_vld0", out_valid, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("b2b_vld2", out_valid, 1'b1);
    chk("b2b_hold", out,       4'h6);
`ifdef SIPO_PARITY_EN
    send_bit(1'b1);
    out_ready = 1'b1;
    send_bit(1'b0);
`else
    out_ready = 1'b1;
    send_bit(1'b1);
`endif
    chk("b2b_out", out,       4'hF);
    chk("b2b_vld", out_valid, 1'b1);
    chk("b2b_ovr", overrun,   1'b0);
    tick();
    out_ready = 1'b0;
    chk("b2b_acc", out_valid, 1'b0);

    // Overrun: A held, 5 dropped.
    send_frame(4'hA, 1'b0);
    chk("ovr_first", out, 4'hA);
    send_frame(4'h5, 1'b0);
    chk("ovr_out", out,       4'hA);
    chk("ovr_flag", overrun,  1'b1);
    chk("ovr_vld", out_valid, 1'b1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 1'b0);
    chk("ovr_clr_out", out, 4'hA);

    // Drop on the same edge as ovr_clr: set wins.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0);
`endif
    ovr_clr = 1'b1;
    send_bit(1'b0);
    ovr_clr = 1'b0;
    chk("ovr_prio", overrun, 1'b1);
    chk("ovr_prio_out", out, 4'hA);
    ovr_clr = 1'b1; out_ready = 1'b1; tick(); ovr_clr = 1'b0; out_ready = 1'b0;
    chk("ovr_clr2", overrun,   1'b0);
    chk("ovr_acc",  out_valid, 1'b0);

    // Sync: partial frame discarded, sync edge bit becomes bit 0.
    send_bit(1'b1); send_bit(1'b0);
    sync = 1'b1;
    send_bit(1'b1);
    sync = 1'b0;
    chk("sync_busy", busy,      1'b1);
    chk("sync_vld",  out_valid, 1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0);
`endif
    chk("sync_out",   out,       4'h9);
    chk("sync_vld2",  out_valid, 1'b1);
    chk("sync_busy2", busy,      1'b0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

`ifdef SIPO_PARITY_EN
    send_frame(4'hB, 1'b0);
    chk("par_ok_out", out,        4'hB);
    chk("par_ok",     parity_err, 1'b0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    send_frame(4'hB, 1'b1);
    chk("par_bad_out", out,        4'hB);
    chk("par_bad",     parity_err, 1'b1);
`else
    chk("par_tied", parity_err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
